// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter controller for the instruction-fetch stage.
// Owns the PC register, drives the next-PC mux select, and sequences fetch
// through idle, free-running, single-step and halted modes.
module pc_fetch_ctrl #(
  parameter int addr_width = 10,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [addr_width-1:0] branch_target,
  input  logic                  halt_detected,
  output logic [addr_width-1:0] pc,
  output logic                  pc_sel,
  output logic                  imem_en,
  output logic                  if_flush,
  output logic                  running,
  output logic                  halted,
  output logic [cnt_width-1:0]  fetch_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [addr_width-1:0] PC_ONE  = {{(addr_width-1){1'b0}}, 1'b1};
  localparam logic [cnt_width-1:0]  CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

  logic [1:0]            state, state_nxt;
  logic                  step_pending, pending_nxt;
  logic                  adv;
  logic [addr_width-1:0] pc_nxt;
  logic [cnt_width-1:0]  cnt_nxt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    if (&v) return v;
    return v + CNT_ONE;
  endfunction

  // PC increment; wraps from all-ones back to zero by natural overflow.
  function automatic logic [addr_width-1:0] pc_inc(input logic [addr_width-1:0] v);
    return v + PC_ONE;
  endfunction

  // Advance qualifier: halt beats stall and branch; a mode switch costs one cycle.
  always_comb begin
    adv = 1'b0;
    if (!reset) begin
      case (state)
        S_RUN:   adv = !stall && !halt_detected && !step_mode;
        S_STEP:  adv = (step || step_pending) && !stall && !halt_detected && step_mode;
        default: adv = 1'b0;
      endcase
    end
  end

  // Next-state, pending-step and PC/counter selection.
  always_comb begin
    state_nxt   = state;
    pending_nxt = step_pending;
    pc_nxt      = pc;
    cnt_nxt     = fetch_count;
    case (state)
      S_IDLE: begin
        pending_nxt = 1'b0;
        if (start) state_nxt = step_mode ? S_STEP : S_RUN;
      end
      S_RUN: begin
        pending_nxt = 1'b0;
        if (halt_detected)  state_nxt = S_HALT;
        else if (step_mode) state_nxt = S_STEP;
      end
      S_STEP: begin
        if (halt_detected) begin
          state_nxt   = S_HALT;
          pending_nxt = 1'b0;
        end else if (!step_mode) begin
          state_nxt   = S_RUN;
          pending_nxt = 1'b0;
        end else if (stall) begin
          // Any number of steps during one stall collapse into one advance.
          if (step) pending_nxt = 1'b1;
        end else if (adv) begin
          pending_nxt = 1'b0;
        end
      end
      default: begin
        pending_nxt = 1'b0;
        if (start) begin
          state_nxt = step_mode ? S_STEP : S_RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
    endcase
    if (adv) begin
      pc_nxt  = branch_taken ? branch_target : pc_inc(pc);
      cnt_nxt = sat_inc(fetch_count);
    end
  end

  // State, PC and retired-fetch counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      step_pending <= 1'b0;
      pc           <= '0;
      fetch_count  <= '0;
    end else begin
      state        <= state_nxt;
      step_pending <= pending_nxt;
      pc           <= pc_nxt;
      fetch_count  <= cnt_nxt;
    end
  end

  assign pc_sel   = adv && branch_taken;
  assign if_flush = adv && branch_taken;
  assign imem_en  = (state == S_RUN) || (state == S_STEP);
  assign running  = (state == S_RUN);
  assign halted   = (state == S_HALT);

endmodule
